// File: rtl/note_player_pkg.sv
// -----------------------------------------------------------------------------
// note_player_pkg
// Shared constants for the note player: note/duration/phase widths, FSM state
// encoding, the rest note number and the nominal audio sample rate that the
// frequency ROM contents were generated for.
// -----------------------------------------------------------------------------
package note_player_pkg;

    localparam int NOTE_W      = 6;      // note number width, 0 = rest
    localparam int DUR_W       = 6;      // duration width in beats
    localparam int STEP_W      = 20;     // phase step / accumulator width

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam int NOTE_REST   = 0;
    localparam int SAMPLE_RATE = 48000;

endpackage

// File: rtl/note_player_freq_rom.sv
// -----------------------------------------------------------------------------
// note_player_freq_rom
// Registered 64 x STEP_W lookup from note number to phase step.
// Entry n = round(440 * 2^((n-46)/12) * 2^STEP_W / SAMPLE_RATE), n = 1..63;
// entry 0 (rest) is 0 so a rest is silent.
//
// Ports:
//   clk_i   system clock
//   addr_i  note number (registered note from the player)
//   dout_o  phase step, valid one clock after addr_i
// -----------------------------------------------------------------------------
module note_player_freq_rom
    import note_player_pkg::*;
(
    input  logic              clk_i,
    input  logic [NOTE_W-1:0] addr_i,
    output logic [STEP_W-1:0] dout_o
);

    function automatic logic [STEP_W-1:0] lookup(input logic [NOTE_W-1:0] n);
        case (n)
            NOTE_W'(NOTE_REST): lookup = '0;
            6'd1:  lookup = 20'd714;    6'd2:  lookup = 20'd757;
            6'd3:  lookup = 20'd802;    6'd4:  lookup = 20'd850;
            6'd5:  lookup = 20'd900;    6'd6:  lookup = 20'd954;
            6'd7:  lookup = 20'd1010;   6'd8:  lookup = 20'd1070;
            6'd9:  lookup = 20'd1134;   6'd10: lookup = 20'd1201;
            6'd11: lookup = 20'd1273;   6'd12: lookup = 20'd1349;
            6'd13: lookup = 20'd1429;   6'd14: lookup = 20'd1514;
            6'd15: lookup = 20'd1604;   6'd16: lookup = 20'd1699;
            6'd17: lookup = 20'd1800;   6'd18: lookup = 20'd1907;
            6'd19: lookup = 20'd2021;   6'd20: lookup = 20'd2141;
            6'd21: lookup = 20'd2268;   6'd22: lookup = 20'd2403;
            6'd23: lookup = 20'd2546;   6'd24: lookup = 20'd2697;
            6'd25: lookup = 20'd2858;   6'd26: lookup = 20'd3028;
            6'd27: lookup = 20'd3208;   6'd28: lookup = 20'd3398;
            6'd29: lookup = 20'd3600;   6'd30: lookup = 20'd3815;
            6'd31: lookup = 20'd4041;   6'd32: lookup = 20'd4282;
            6'd33: lookup = 20'd4536;   6'd34: lookup = 20'd4806;
            6'd35: lookup = 20'd5092;   6'd36: lookup = 20'd5395;
            6'd37: lookup = 20'd5715;   6'd38: lookup = 20'd6055;
            6'd39: lookup = 20'd6415;   6'd40: lookup = 20'd6797;
            6'd41: lookup = 20'd7201;   6'd42: lookup = 20'd7629;
            6'd43: lookup = 20'd8083;   6'd44: lookup = 20'd8563;
            6'd45: lookup = 20'd9072;   6'd46: lookup = 20'd9612;
            6'd47: lookup = 20'd10184;  6'd48: lookup = 20'd10789;
            6'd49: lookup = 20'd11431;  6'd50: lookup = 20'd12110;
            6'd51: lookup = 20'd12830;  6'd52: lookup = 20'd13593;
            6'd53: lookup = 20'd14402;  6'd54: lookup = 20'd15258;
            6'd55: lookup = 20'd16165;  6'd56: lookup = 20'd17127;
            6'd57: lookup = 20'd18145;  6'd58: lookup = 20'd19224;
            6'd59: lookup = 20'd20367;  6'd60: lookup = 20'd21578;
            6'd61: lookup = 20'd22861;  6'd62: lookup = 20'd24221;
            6'd63: lookup = 20'd25661;
            default: lookup = '0;
        endcase
    endfunction

    // Pure data register: no reset, the player gates the output until valid.
    always_ff @(posedge clk_i) begin
        dout_o <= lookup(addr_i);
    end

endmodule

// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
// Consumer end of the song reader's note handshake. Latches one note per
// new_note strobe, holds it for `duration` beats, then pulses note_done for one
// cycle. The held note addresses a registered frequency ROM whose step drives a
// phase accumulator for the downstream sine/codec path.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   play         1 = run, 0 = pause (beat count and phase frozen, step = 0)
//   new_note     one-cycle strobe, note/duration valid this cycle
//   note         note number, 0 = rest
//   duration     note length in beats
//   beat         one-cycle beat tick
//   sample_tick  one-cycle audio sample strobe
//   note_done    one-cycle pulse when the current note expires
//   playing      1 while a note is held
//   step         phase increment of the current note, 0 when rest/paused/idle
//   phase        phase accumulator value
//
// Build option: define NOTE_PLAYER_ARTIC_EN to mute the last beat of notes
// that are two or more beats long (articulation gap between repeated notes).
// -----------------------------------------------------------------------------
module note_player
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic              beat,
    input  logic              sample_tick,
    output logic              note_done,
    output logic              playing,
    output logic [STEP_W-1:0] step,
    output logic [STEP_W-1:0] phase
);

    state_e              state_q, state_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [STEP_W-1:0]   phase_q, phase_d;
    logic                rom_vld_q;
    logic                load;
    logic                artic_mute;
    logic [STEP_W-1:0]   step_raw;

    note_player_freq_rom u_freq_rom (
        .clk_i  (clk),
        .addr_i (note_q),
        .dout_o (step_raw)
    );

`ifdef NOTE_PLAYER_ARTIC_EN
    logic [DUR_W-1:0] dur_orig_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dur_orig_q <= '0;
        end else if (load) begin
            dur_orig_q <= duration;
        end
    end

    assign artic_mute = (dur_orig_q >= DUR_W'(2)) && (dur_cnt_q == DUR_W'(1));
`else
    assign artic_mute = 1'b0;
`endif

    // The ROM lags note_q by one clock; rom_vld_q masks the stale entry of the
    // previous note in the first cycle after a latch.
    always_comb begin
        step = '0;
        if (state_q == S_PLAYING && play && rom_vld_q && !artic_mute) begin
            step = step_raw;
        end
    end

    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        dur_cnt_d = dur_cnt_q;
        phase_d   = phase_q;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                load = new_note;
            end
            S_PLAYING: begin
                // A new note preempts, even when it collides with the final beat.
                if (new_note) begin
                    load = 1'b1;
                end else if (beat && play) begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    if (dur_cnt_q == DUR_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                load    = new_note;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            note_d    = note;
            dur_cnt_d = duration;
            phase_d   = '0;
            state_d   = (duration != '0) ? S_PLAYING : S_DONE;
        end else if (sample_tick && play && state_q == S_PLAYING) begin
            phase_d = phase_q + step;   // natural modulo-2^STEP_W wrap
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            note_q    <= '0;
            dur_cnt_q <= '0;
            phase_q   <= '0;
            rom_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            dur_cnt_q <= dur_cnt_d;
            phase_q   <= phase_d;
            rom_vld_q <= ~load;
        end
    end

    assign note_done = (state_q == S_DONE);
    assign playing   = (state_q == S_PLAYING);
    assign phase     = phase_q;

endmodule

// File: tb/tb_note_player.sv
`timescale 1ns/1ps
module tb_note_player;
    import note_player_pkg::*;

    localparam int PMOD = 1 << STEP_W;
`ifdef NOTE_PLAYER_ARTIC_EN
    localparam bit ARTIC = 1'b1;
`else
    localparam bit ARTIC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              beat;
    logic              sample_tick;
    logic              note_done;
    logic              playing;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] phase;

    always #5 clk = ~clk;

    note_player dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .new_note    (new_note),
        .note        (note),
        .duration    (duration),
        .beat        (beat),
        .sample_tick (sample_tick),
        .note_done   (note_done),
        .playing     (playing),
        .step        (step),
        .phase       (phase)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the note currently held and how many beats remain.
    bit m_busy  = 1'b0;
    int m_note  = 0;
    int m_left  = 0;
    int m_orig  = 0;
    int m_age   = 1;
    int m_phase = 0;

    // Expected outputs for the current cycle, sampled by the monitor.
    bit e_play    = 1'b0;
    int e_step    = 0;
    bit e_step_dc = 1'b0;
    int e_phase   = 0;
    bit chk_en    = 1'b0;

    int done_q[$];

    function automatic int rom_ref(input int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * (2.0 ** ((n - 46) / 12.0));
        return $rtoi(f * real'(PMOD) / real'(SAMPLE_RATE) + 0.5);
    endfunction

    function automatic int model_step(input bit pl);
        if (!m_busy || !pl) return 0;
        if (ARTIC && m_orig >= 2 && m_left == 1) return 0;
        return rom_ref(m_note);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; expected outputs for this cycle and the model's
    // next state are computed from the rules for holding and timing a note.
    task automatic cyc1(input bit nn, input int nt, input int du,
                        input bit bt, input bit st, input bit pl);
        @(posedge clk);
        #1;
        if (m_age == 0) st = 1'b0;   // step is not yet defined the cycle after a latch
        new_note    = nn;
        note        = NOTE_W'(nt);
        duration    = DUR_W'(du);
        beat        = bt;
        sample_tick = st;
        play        = pl;
        e_play      = m_busy;
        e_step      = model_step(pl);
        e_step_dc   = (m_age == 0);
        e_phase     = m_phase;
        if (nn) begin
            m_note  = nt;
            m_left  = du;
            m_orig  = du;
            m_phase = 0;
            m_age   = 0;
            m_busy  = (du != 0);
            if (du == 0) done_q.push_back(cyc + 1);
        end else begin
            m_age++;
            if (m_busy && pl) begin
                if (st) m_phase = (m_phase + e_step) % PMOD;
                if (bt) begin
                    if (m_left == 1) begin
                        m_busy = 1'b0;
                        done_q.push_back(cyc + 1);
                    end else begin
                        m_left--;
                    end
                end
            end
        end
    endtask

    task automatic run(input int n, input int bp, input int tp, input bit pl);
        for (int i = 0; i < n; i++) begin
            cyc1(1'b0, 0, 0, (bp > 0) && (i % bp == bp - 1), (tp > 0) && (i % tp == 0), pl);
        end
    endtask

    task automatic reset_mid_note();
        @(posedge clk);
        #1;
        new_note = 1'b0; beat = 1'b0; sample_tick = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rst_playing", int'(playing), 0);
        chk("async_rst_step", int'(step), 0);
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_note_done", int'(note_done), 0);
        m_busy = 1'b0; m_phase = 0; m_age = 1;
        done_q.delete();
        e_play = 1'b0; e_step = 0; e_step_dc = 1'b0; e_phase = 0;
        repeat (3) cyc1(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("playing", int'(playing), int'(e_play));
            if (!e_step_dc) chk("step", int'(step), e_step);
            chk("phase", int'(phase), e_phase);
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                chk("note_done", int'(note_done), 1);
            end else begin
                chk("note_done", int'(note_done), 0);
            end
        end
    end

    initial begin
        bit pl_r;
        reset = 1'b0; play = 1'b0; new_note = 1'b0; note = '0;
        duration = '0; beat = 1'b0; sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_playing", int'(playing), 0);
        chk("reset_step", int'(step), 0);
        chk("reset_phase", int'(phase), 0);
        chk("reset_note_done", int'(note_done), 0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // Basic 440 Hz note, three beats 100 cycles apart.
        cyc1(1'b1, 46, 3, 1'b0, 1'b0, 1'b1);
        cyc1(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc1(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        chk("a4_step_t2", int'(step), 9612);
        run(350, 100, 7, 1'b1);

        // Rest timed like a note, then a zero-length note.
        cyc1(1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
        run(30, 10, 3, 1'b1);
        cyc1(1'b1, 10, 0, 1'b0, 1'b0, 1'b1);
        run(5, 0, 0, 1'b1);

        // Pause after the first beat of a 4-beat note; paused beats are lost.
        cyc1(1'b1, 20, 4, 1'b0, 1'b0, 1'b1);
        run(12, 10, 2, 1'b1);
        run(50, 10, 2, 1'b0);
        run(40, 10, 2, 1'b1);

        // Preempt on the second beat of a 5-beat note.
        cyc1(1'b1, 30, 5, 1'b0, 1'b0, 1'b1);
        run(19, 10, 3, 1'b1);
        cyc1(1'b1, 31, 3, 1'b1, 1'b0, 1'b1);
        run(40, 10, 3, 1'b1);

        // New note in the same cycle as the final beat.
        cyc1(1'b1, 40, 2, 1'b0, 1'b0, 1'b1);
        run(10, 10, 3, 1'b1);
        run(9, 0, 3, 1'b1);
        cyc1(1'b1, 41, 2, 1'b1, 1'b0, 1'b1);
        run(30, 10, 3, 1'b1);

        // Articulation: a 3-beat note and a 1-beat note.
        cyc1(1'b1, 50, 3, 1'b0, 1'b0, 1'b1);
        run(40, 10, 3, 1'b1);
        cyc1(1'b1, 51, 1, 1'b0, 1'b0, 1'b1);
        run(15, 10, 3, 1'b1);

        // Phase wrap: 1000 sample ticks of the highest note, then reset mid-note.
        cyc1(1'b1, 63, 63, 1'b0, 1'b0, 1'b1);
        cyc1(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        run(1000, 0, 1, 1'b1);
        cyc1(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        chk("phase_wrap_1000", int'(phase), (1000 * rom_ref(63)) % PMOD);
        reset_mid_note();
        run(5, 0, 0, 1'b1);

        // Randomized traffic.
        pl_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bit nn, bt, st;
            int nt, du;
            nn = ($urandom_range(0, 39) == 0);
            nt = $urandom_range(0, 63);
            du = $urandom_range(0, 5);
            bt = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) pl_r = ~pl_r;
            cyc1(nn, nt, du, bt, st, pl_r);
        end

        run(400, 10, 3, 1'b1);
        run(3, 0, 0, 1'b1);
        chk("done_queue_drained", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
